// File: rtl/uart_frame_rx.sv
// rtl/uart_frame_rx.sv - UART frame receiver with parity/stop checking and a one-word output holding register
module uart_frame_rx #(
  parameter int CLKS_PER_BIT = 217,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 data_valid,
  input  logic                 data_ready,
  output logic                 parity_error,
  output logic                 framing_error,
  output logic                 overrun,
  output logic                 receiving
);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PAR,
    STOP,
    BREAK
  } state_t;

  localparam logic [15:0] CNT_MID   = 16'(CLKS_PER_BIT / 2);
  localparam logic [15:0] CNT_END   = 16'(CLKS_PER_BIT - 1);
  localparam logic [3:0]  LAST_BIT  = 4'(DATA_BITS - 1);
  localparam logic        LAST_STOP = (STOP_BITS == 2);
  localparam logic        ODD_PAR   = (PARITY == 2);

  state_t                 r_state;
  state_t                 w_next;
  logic                   r_sync1;
  logic                   r_sync2;
  logic [15:0]            r_cnt;
  logic [3:0]             r_bit_idx;
  logic                   r_stop_idx;
  logic [DATA_BITS-1:0]   r_shift;
  logic                   r_par_calc;
  logic [DATA_BITS-1:0]   r_data;
  logic                   r_valid;
  logic                   r_perr;
  logic                   r_ferr;
  logic                   r_ovr;

  logic w_rx_s;
  logic w_cnt_clr;
  logic w_start_ok;
  logic w_data_smp;
  logic w_par_smp;
  logic w_stop_smp;
  logic w_frame_bad;
  logic w_deliver;
  logic w_hs;
  logic w_load;

  assign w_rx_s = r_sync2;

  // Synchronizer flops reset to the idle line level so no false start follows reset.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= rx;
      r_sync2 <= r_sync1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next      = r_state;
    w_cnt_clr   = 1'b0;
    w_start_ok  = 1'b0;
    w_data_smp  = 1'b0;
    w_par_smp   = 1'b0;
    w_stop_smp  = 1'b0;
    w_frame_bad = 1'b0;
    w_deliver   = 1'b0;
    case (r_state)
      IDLE: begin
        w_cnt_clr = 1'b1;
        if (!w_rx_s) w_next = START;
      end
      START: begin
        if (r_cnt == CNT_MID) begin
          w_cnt_clr = 1'b1;
          if (!w_rx_s) begin
            w_next     = DATA;
            w_start_ok = 1'b1;
          end else begin
            w_next = IDLE;
          end
        end
      end
      DATA: begin
        if (r_cnt == CNT_END) begin
          w_cnt_clr  = 1'b1;
          w_data_smp = 1'b1;
          if (r_bit_idx == LAST_BIT) w_next = (PARITY != 0) ? PAR : STOP;
        end
      end
      PAR: begin
        if (r_cnt == CNT_END) begin
          w_cnt_clr = 1'b1;
          w_par_smp = 1'b1;
          w_next    = STOP;
        end
      end
      STOP: begin
        if (r_cnt == CNT_END) begin
          w_cnt_clr  = 1'b1;
          w_stop_smp = 1'b1;
          if (!w_rx_s) begin
            w_next      = BREAK;
            w_frame_bad = 1'b1;
          end else if (r_stop_idx == LAST_STOP) begin
            w_next    = IDLE;
            w_deliver = 1'b1;
          end
        end
      end
      BREAK: begin
        w_cnt_clr = 1'b1;
        if (w_rx_s) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_cnt      <= 16'd0;
      r_bit_idx  <= 4'd0;
      r_stop_idx <= 1'b0;
      r_shift    <= '0;
      r_par_calc <= 1'b0;
      r_ferr     <= 1'b0;
    end else begin
      r_cnt <= w_cnt_clr ? 16'd0 : r_cnt + 16'd1;
      if (w_start_ok) begin
        r_bit_idx  <= 4'd0;
        r_stop_idx <= 1'b0;
        r_par_calc <= 1'b0;
        r_ferr     <= 1'b0;
      end else begin
        if (w_data_smp) r_bit_idx <= r_bit_idx + 4'd1;
        if (w_stop_smp) r_stop_idx <= r_stop_idx + 1'b1;
        // Shift is complete by the parity sample, so the reduction covers the full word.
        if (w_par_smp) r_par_calc <= (^r_shift) ^ w_rx_s ^ ODD_PAR;
        if (w_frame_bad) r_ferr <= 1'b1;
      end
      // Shifting in at the MSB leaves the first (LSB) bit at position 0 after DATA_BITS samples.
      if (w_data_smp) r_shift <= {w_rx_s, r_shift[DATA_BITS-1:1]};
    end
  end

  assign w_hs   = r_valid & data_ready;
  assign w_load = w_deliver & (~r_valid | w_hs);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_data  <= '0;
      r_valid <= 1'b0;
      r_perr  <= 1'b0;
      r_ovr   <= 1'b0;
    end else begin
      if (w_load) begin
        r_data  <= r_shift;
        r_perr  <= r_par_calc;
        r_valid <= 1'b1;
      end else if (w_hs) begin
        r_valid <= 1'b0;
      end
      if (w_hs) r_ovr <= 1'b0;
      else if (w_deliver && r_valid) r_ovr <= 1'b1;
    end
  end

  assign data_out      = r_data;
  assign data_valid    = r_valid;
  assign parity_error  = r_perr;
  assign framing_error = r_ferr;
  assign overrun       = r_ovr;
  assign receiving     = (r_state != IDLE);

endmodule

// File: tb/tb_uart_frame_rx.sv
// tb/tb_uart_frame_rx.sv - scoreboard bench for uart_frame_rx (default 8N1 and 7E1 instances)
module tb_uart_frame_rx;
  localparam int CPB_A = 217;
  localparam int CPB_B = 16;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic rx_a = 1'b1, rx_b = 1'b1;
  logic ready_a = 1'b0, ready_b = 1'b0;
  logic [7:0] data_a;
  logic [6:0] data_b;
  logic valid_a, perr_a, ferr_a, ovr_a, recv_a;
  logic valid_b, perr_b, ferr_b, ovr_b, recv_b;

  int n_checks = 0;
  int n_fail = 0;
  int cyc = 0;
  int last_rise = 0;
  int start_cycle = 0;
  logic prev_valid = 1'b0;
  logic [9:0] sb[$];

  always #5 clock = ~clock;

  uart_frame_rx #(.CLKS_PER_BIT(CPB_A)) dut_a (
    .clock(clock), .reset(reset), .rx(rx_a), .data_out(data_a), .data_valid(valid_a),
    .data_ready(ready_a), .parity_error(perr_a), .framing_error(ferr_a), .overrun(ovr_a),
    .receiving(recv_a)
  );

  uart_frame_rx #(.CLKS_PER_BIT(CPB_B), .DATA_BITS(7), .PARITY(1), .STOP_BITS(1)) dut_b (
    .clock(clock), .reset(reset), .rx(rx_b), .data_out(data_b), .data_valid(valid_b),
    .data_ready(ready_b), .parity_error(perr_b), .framing_error(ferr_b), .overrun(ovr_b),
    .receiving(recv_b)
  );

  always @(posedge clock) begin
    cyc <= cyc + 1;
    prev_valid <= valid_a;
    if (valid_a && !prev_valid) last_rise <= cyc;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic send_bits(input bit to_b, input logic [15:0] bits, input int nbits, input int cpb);
    @(posedge clock); #1;
    start_cycle = cyc;
    for (int i = 0; i < nbits; i++) begin
      if (to_b) rx_b = bits[i];
      else      rx_a = bits[i];
      repeat (cpb) @(posedge clock);
      #1;
    end
  endtask

  task automatic send_a(input logic [7:0] d, input logic stop_bit);
    send_bits(1'b0, {6'b0, stop_bit, d, 1'b0}, 10, CPB_A);
  endtask

  task automatic send_b(input logic [6:0] d, input logic par_bit);
    send_bits(1'b1, {6'b0, 1'b1, par_bit, d, 1'b0}, 10, CPB_B);
  endtask

  task automatic wait_valid(input bit to_b, input string tag);
    int n = 0;
    while (!(to_b ? valid_b : valid_a) && n < 3000) begin
      @(negedge clock);
      n++;
    end
    check_eq({tag, "_valid"}, to_b ? valid_b : valid_a, 1);
  endtask

  task automatic pop_check(input bit to_b, input string tag);
    logic [9:0] exp;
    check_eq({tag, "_sb_nonempty"}, sb.size() > 0, 1);
    if (sb.size() > 0) begin
      exp = sb.pop_front();
      check_eq({tag, "_data"}, to_b ? {25'b0, data_b} : {24'b0, data_a}, {23'b0, exp[8:0]});
      check_eq({tag, "_perr"}, to_b ? perr_b : perr_a, exp[9]);
    end
  endtask

  task automatic consume(input bit to_b, input string tag);
    @(posedge clock); #1;
    if (to_b) ready_b = 1'b1; else ready_a = 1'b1;
    @(posedge clock); #1;
    ready_a = 1'b0;
    ready_b = 1'b0;
    @(negedge clock);
    check_eq({tag, "_cleared"}, to_b ? valid_b : valid_a, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    #1;
    check_eq("rst_valid", valid_a, 0);
    check_eq("rst_data", data_a, 0);
    check_eq("rst_flags", {perr_a, ferr_a, ovr_a, recv_a}, 0);
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    check_eq("post_rst_recv", recv_a, 0);
    check_eq("post_rst_valid_b", valid_b, 0);

    // Basic frame, consumer stalled
    sb.push_back({1'b0, 1'b0, 8'h0E});
    send_a(8'h0E, 1'b1);
    wait_valid(0, "f0e");
    pop_check(0, "f0e");
    check_eq("f0e_flags", {ferr_a, ovr_a}, 0);
    lat = last_rise - start_cycle;
    check_eq("f0e_latency", (lat >= 9 * CPB_A) && (lat <= 10 * CPB_A + 8), 1);
    consume(0, "f0e");

    // Start glitch
    rx_a = 1'b0;
    repeat (20) @(posedge clock);
    #1 check_eq("glitch_recv_hi", recv_a, 1);
    repeat (30) @(posedge clock);
    #1 rx_a = 1'b1;
    repeat (200) @(posedge clock);
    #1;
    check_eq("glitch_recv_lo", recv_a, 0);
    check_eq("glitch_valid", valid_a, 0);
    check_eq("glitch_ferr", ferr_a, 0);

    // Bad stop bit, line held low
    send_a(8'h55, 1'b0);
    repeat (300) @(posedge clock);
    #1;
    check_eq("brk_ferr", ferr_a, 1);
    check_eq("brk_recv", recv_a, 1);
    check_eq("brk_valid", valid_a, 0);
    rx_a = 1'b1;
    repeat (10) @(posedge clock);
    #1;
    check_eq("brk_exit_recv", recv_a, 0);
    check_eq("brk_ferr_sticky", ferr_a, 1);
    sb.push_back({1'b0, 1'b0, 8'hA3});
    send_a(8'hA3, 1'b1);
    wait_valid(0, "fa3");
    pop_check(0, "fa3");
    check_eq("fa3_ferr", ferr_a, 0);
    consume(0, "fa3");

    // Overrun
    sb.push_back({1'b0, 1'b0, 8'h11});
    send_a(8'h11, 1'b1);
    wait_valid(0, "f11");
    send_a(8'h22, 1'b1);
    repeat (5) @(posedge clock);
    #1;
    check_eq("ovr_set", ovr_a, 1);
    pop_check(0, "f11");
    consume(0, "ovr");
    check_eq("ovr_cleared", ovr_a, 0);

    // Reset during data bit 4 with a held word
    sb.push_back({1'b0, 1'b0, 8'h3C});
    send_a(8'h3C, 1'b1);
    wait_valid(0, "f3c");
    pop_check(0, "f3c");
    send_bits(1'b0, {7'b0, 8'h7E, 1'b0}, 5, CPB_A);
    rx_a = 1'b1;
    repeat (100) @(posedge clock);
    #1;
    check_eq("mid_recv", recv_a, 1);
    #3 reset = 1'b1;
    #1;
    check_eq("mid_rst_valid", valid_a, 0);
    check_eq("mid_rst_data", data_a, 0);
    check_eq("mid_rst_flags", {perr_a, ferr_a, ovr_a, recv_a}, 0);
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
    repeat (3000) @(posedge clock);
    #1 check_eq("mid_no_delivery", valid_a, 0);
    sb.push_back({1'b0, 1'b0, 8'h7E});
    send_a(8'h7E, 1'b1);
    wait_valid(0, "f7e");
    pop_check(0, "f7e");
    check_eq("f7e_flags", {ferr_a, ovr_a}, 0);
    consume(0, "f7e");

    // 7-bit even parity instance
    sb.push_back({1'b1, 2'b0, 7'h41});
    send_b(7'h41, 1'b1);
    wait_valid(1, "par_bad");
    pop_check(1, "par_bad");
    consume(1, "par_bad");
    sb.push_back({1'b0, 2'b0, 7'h41});
    send_b(7'h41, 1'b0);
    wait_valid(1, "par_ok");
    pop_check(1, "par_ok");
    check_eq("par_ok_ferr", ferr_b, 0);
    consume(1, "par_ok");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
